// File: rtl/delay_timer_pkg.sv
// Shared constants for the multi-channel millisecond delay timer.
// Mode and state encodings plus a constant-function ceiling log2.
package delay_timer_pkg;

    localparam logic [1:0] MODE_LEVEL  = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_RETRIG = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    function automatic int clog2(input int value);
        int v;
        int r;
        r = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/delay_timer_if.sv
// Per-channel control/status bundle for delay_timer_mc; the timer is the slave.
// No backpressure: every signal is a plain level sampled or driven each cycle.
interface delay_timer_if #(
    parameter int CH     = 4,
    parameter int DATA_W = 12
);
    logic [CH-1:0]        i_start;
    logic [CH-1:0]        i_abort;
    logic [CH-1:0]        i_dly_en;
    logic [CH*DATA_W-1:0] i_data;
    logic [CH*2-1:0]      i_mode;
    logic [CH-1:0]        o_delay_time;
    logic [CH-1:0]        o_busy;
    logic [CH-1:0]        o_done_pulse;

    modport master (
        output i_start, i_abort, i_dly_en, i_data, i_mode,
        input  o_delay_time, o_busy, o_done_pulse
    );

    modport slave (
        input  i_start, i_abort, i_dly_en, i_data, i_mode,
        output o_delay_time, o_busy, o_done_pulse
    );
endinterface

// File: rtl/delay_timer_ch.sv
// One timer channel: 2-flop start sync, edge detect, IDLE/RUN/EXPIRED FSM, down-counter.
// Load of L ticks one edge after the synchronised start edge; expiry exactly L+1 edges later.
module delay_timer_ch
    import delay_timer_pkg::*;
#(
    parameter int DATA_W       = 12,
    parameter int TICKS_PER_MS = 8
) (
    input  logic              i_clk_8k,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_dly_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_mode,
    output logic              o_delay_time,
    output logic              o_busy,
    output logic              o_done_pulse
);

    localparam int CNT_RAW = DATA_W + clog2(TICKS_PER_MS);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] TPM = CNT_W'(TICKS_PER_MS);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             start_edge;
    logic             load;

    always_comb begin
        s1_d       = i_start;
        s2_d       = s1_q;
        start_edge = s1_q & ~s2_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE, ST_EXPIRED: load = start_edge;
            ST_RUN: begin
                if (start_edge && (mode_q == MODE_RETRIG)) begin
                    load = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_EXPIRED;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_RUN;
            cnt_d   = CNT_W'(i_data) * TPM;
            mode_d  = i_mode;
        end

        // Abort wins over everything, including a coincident start edge.
        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            mode_d  = mode_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk_8k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '1;
            mode_q  <= MODE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign o_busy       = (state_q == ST_RUN);
    assign o_done_pulse = done_q;
    assign o_delay_time = i_dly_en &
                          ((mode_q == MODE_PULSE) ? done_q : (state_q == ST_EXPIRED));

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel millisecond delay timer: CH independent delay_timer_ch instances.
// Latency per channel is fixed by the loaded delay; no backpressure, no arbitration.
module delay_timer_mc #(
    parameter int CH           = 4,
    parameter int DATA_W       = 12,
    parameter int TICKS_PER_MS = 8
) (
    input logic          i_clk_8k,
    input logic          i_rst_n,
    delay_timer_if.slave bus
);

    logic [CH-1:0] delay_time;
    logic [CH-1:0] busy;
    logic [CH-1:0] done_pulse;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        delay_timer_ch #(
            .DATA_W       (DATA_W),
            .TICKS_PER_MS (TICKS_PER_MS)
        ) u_ch (
            .i_clk_8k     (i_clk_8k),
            .i_rst_n      (i_rst_n),
            .i_start      (bus.i_start[g]),
            .i_abort      (bus.i_abort[g]),
            .i_dly_en     (bus.i_dly_en[g]),
            .i_data       (bus.i_data[g*DATA_W +: DATA_W]),
            .i_mode       (bus.i_mode[g*2 +: 2]),
            .o_delay_time (delay_time[g]),
            .o_busy       (busy[g]),
            .o_done_pulse (done_pulse[g])
        );
    end

    assign bus.o_delay_time = delay_time;
    assign bus.o_busy       = busy;
    assign bus.o_done_pulse = done_pulse;

endmodule
